// File: rtl/peripheral_bus_decoder.sv
// Address decoder between the CPU data-bus master and memory-mapped peripherals.
// Forwards registered write/read strobes to one device, tracks a single
// outstanding read, and answers decode misses and timeouts with an error.
module peripheral_bus_decoder #(
    parameter int unsigned NUM_DEVICES    = 4,
    parameter int unsigned DEVICE_SHIFT   = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERROR_DATA     = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [31:0]               host_address,
    input  logic                      host_write_req,
    input  logic [31:0]               host_write_data,
    input  logic [3:0]                host_byte_enable,
    input  logic                      host_read_req,
    output logic [31:0]               host_read_data,
    output logic                      host_read_data_valid,
    output logic                      host_busy,
    output logic                      host_error,
    output logic [DEVICE_SHIFT-1:0]   dev_address,
    output logic [31:0]               dev_write_data,
    output logic [3:0]                dev_byte_enable,
    output logic [NUM_DEVICES-1:0]    dev_write_req,
    output logic [NUM_DEVICES-1:0]    dev_read_req,
    input  logic [32*NUM_DEVICES-1:0] dev_read_data,
    input  logic [NUM_DEVICES-1:0]    dev_read_data_valid
);

    localparam int unsigned IDX_W     = $clog2(NUM_DEVICES);
    localparam int unsigned UPPER_LSB = DEVICE_SHIFT + IDX_W;
    localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_READ_WAIT
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [TMR_W-1:0]        r_timer, w_timer_nxt;
    logic [IDX_W-1:0]        r_sel, w_sel_nxt;
    logic [31:0]             r_rdata, w_rdata_nxt;
    logic                    r_rvalid, w_rvalid_nxt;
    logic                    r_err, w_err_nxt;
    logic [DEVICE_SHIFT-1:0] r_dev_addr, w_dev_addr_nxt;
    logic [31:0]             r_dev_wdata, w_dev_wdata_nxt;
    logic [3:0]              r_dev_be, w_dev_be_nxt;
    logic [NUM_DEVICES-1:0]  r_dev_wreq, w_dev_wreq_nxt;
    logic [NUM_DEVICES-1:0]  r_dev_rreq, w_dev_rreq_nxt;

    logic [IDX_W-1:0]        w_idx;
    logic [31:0]             w_idx_ext;
    logic                    w_hit;
    logic [NUM_DEVICES-1:0]  w_onehot;
    logic                    w_sel_valid;
    logic [31:0]             w_dev_rdata [NUM_DEVICES];

    assign w_idx       = host_address[DEVICE_SHIFT +: IDX_W];
    assign w_idx_ext   = 32'(w_idx);
    assign w_hit       = (host_address[31:UPPER_LSB] == BASE_ADDR[31:UPPER_LSB]) &&
                         (w_idx_ext < NUM_DEVICES);
    assign w_onehot    = NUM_DEVICES'(1) << w_idx;
    assign w_sel_valid = dev_read_data_valid[r_sel];

    // Split the flat device read-data bus into per-device words.
    always_comb begin
        for (int unsigned k = 0; k < NUM_DEVICES; k++) begin
            w_dev_rdata[k] = dev_read_data[32*k +: 32];
        end
    end

    // Next-state and next-output decode; strobes and pulses default low.
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_sel_nxt       = r_sel;
        w_rdata_nxt     = r_rdata;
        w_rvalid_nxt    = 1'b0;
        w_err_nxt       = 1'b0;
        w_dev_addr_nxt  = r_dev_addr;
        w_dev_wdata_nxt = r_dev_wdata;
        w_dev_be_nxt    = r_dev_be;
        w_dev_wreq_nxt  = '0;
        w_dev_rreq_nxt  = '0;
        case (r_state)
            ST_IDLE: begin
                if (host_write_req && host_read_req) begin
                    w_err_nxt = 1'b1;
                end else if (host_write_req || host_read_req) begin
                    if (w_hit) begin
                        w_dev_addr_nxt  = host_address[DEVICE_SHIFT-1:0];
                        w_dev_wdata_nxt = host_write_data;
                        w_dev_be_nxt    = host_byte_enable;
                        if (host_write_req) begin
                            w_dev_wreq_nxt = w_onehot;
                        end else begin
                            w_dev_rreq_nxt = w_onehot;
                            w_sel_nxt      = w_idx;
                            w_timer_nxt    = '0;
                            w_state_nxt    = ST_READ_WAIT;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                        if (host_read_req) begin
                            w_rdata_nxt  = ERROR_DATA;
                            w_rvalid_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_READ_WAIT: begin
                w_err_nxt   = host_write_req || host_read_req;
                w_timer_nxt = r_timer + 1'b1;
                if (w_sel_valid) begin
                    w_rdata_nxt  = w_dev_rdata[r_sel];
                    w_rvalid_nxt = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else if (r_timer == TMR_LAST) begin
                    w_rdata_nxt  = ERROR_DATA;
                    w_rvalid_nxt = 1'b1;
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; async reset clears everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_sel       <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_dev_addr  <= '0;
            r_dev_wdata <= '0;
            r_dev_be    <= '0;
            r_dev_wreq  <= '0;
            r_dev_rreq  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_sel       <= w_sel_nxt;
            r_rdata     <= w_rdata_nxt;
            r_rvalid    <= w_rvalid_nxt;
            r_err       <= w_err_nxt;
            r_dev_addr  <= w_dev_addr_nxt;
            r_dev_wdata <= w_dev_wdata_nxt;
            r_dev_be    <= w_dev_be_nxt;
            r_dev_wreq  <= w_dev_wreq_nxt;
            r_dev_rreq  <= w_dev_rreq_nxt;
        end
    end

    assign host_read_data       = r_rdata;
    assign host_read_data_valid = r_rvalid;
    assign host_busy            = (r_state == ST_READ_WAIT);
    assign host_error           = r_err;
    assign dev_address          = r_dev_addr;
    assign dev_write_data       = r_dev_wdata;
    assign dev_byte_enable      = r_dev_be;
    assign dev_write_req        = r_dev_wreq;
    assign dev_read_req         = r_dev_rreq;

endmodule

// File: tb/tb_peripheral_bus_decoder.sv
// Self-checking bench for peripheral_bus_decoder: a transaction-level model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_peripheral_bus_decoder;

    localparam int unsigned NUM   = 4;
    localparam int unsigned SHIFT = 8;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned TMO   = 16;
    localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [31:0]        host_address = '0;
    logic               host_write_req = 1'b0;
    logic [31:0]        host_write_data = '0;
    logic [3:0]         host_byte_enable = '0;
    logic               host_read_req = 1'b0;
    logic [31:0]        host_read_data;
    logic               host_read_data_valid;
    logic               host_busy;
    logic               host_error;
    logic [SHIFT-1:0]   dev_address;
    logic [31:0]        dev_write_data;
    logic [3:0]         dev_byte_enable;
    logic [NUM-1:0]     dev_write_req;
    logic [NUM-1:0]     dev_read_req;
    logic [32*NUM-1:0]  dev_read_data = '0;
    logic [NUM-1:0]     dev_read_data_valid = '0;

    int n_checks = 0;
    int n_fail   = 0;

    peripheral_bus_decoder #(
        .NUM_DEVICES(NUM),
        .DEVICE_SHIFT(SHIFT),
        .BASE_ADDR(BASE),
        .TIMEOUT_CYCLES(TMO),
        .ERROR_DATA(ERRD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .host_address(host_address),
        .host_write_req(host_write_req),
        .host_write_data(host_write_data),
        .host_byte_enable(host_byte_enable),
        .host_read_req(host_read_req),
        .host_read_data(host_read_data),
        .host_read_data_valid(host_read_data_valid),
        .host_busy(host_busy),
        .host_error(host_error),
        .dev_address(dev_address),
        .dev_write_data(dev_write_data),
        .dev_byte_enable(dev_byte_enable),
        .dev_write_req(dev_write_req),
        .dev_read_req(dev_read_req),
        .dev_read_data(dev_read_data),
        .dev_read_data_valid(dev_read_data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request is accepted if its address lies inside the region
    // [BASE, BASE + NUM device windows); a read stays outstanding until its
    // device answers or TMO cycles have elapsed since it was issued.
    function automatic bit in_region(input logic [31:0] a);
        longint lo, hi;
        lo = longint'(BASE);
        hi = lo + longint'(NUM) * (longint'(1) << SHIFT);
        return (longint'(a) >= lo) && (longint'(a) < hi);
    endfunction

    longint         cyc = 0;
    longint         m_issue = 0;
    bit             m_inflight = 1'b0;
    int             m_sel = 0;
    logic [31:0]    e_rdata = '0;
    logic           e_valid = 1'b0;
    logic           e_err = 1'b0;
    logic [SHIFT-1:0] e_addr = '0;
    logic [31:0]    e_wdata = '0;
    logic [3:0]     e_be = '0;
    logic [NUM-1:0] e_wreq = '0;
    logic [NUM-1:0] e_rreq = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_inflight <= 1'b0;
            m_sel      <= 0;
            e_rdata    <= '0;
            e_valid    <= 1'b0;
            e_err      <= 1'b0;
            e_addr     <= '0;
            e_wdata    <= '0;
            e_be       <= '0;
            e_wreq     <= '0;
            e_rreq     <= '0;
        end else begin
            e_valid <= 1'b0;
            e_err   <= 1'b0;
            e_wreq  <= '0;
            e_rreq  <= '0;
            if (m_inflight) begin
                e_err <= host_write_req || host_read_req;
                if (dev_read_data_valid[m_sel]) begin
                    e_rdata    <= dev_read_data[32*m_sel +: 32];
                    e_valid    <= 1'b1;
                    m_inflight <= 1'b0;
                end else if (cyc - m_issue == longint'(TMO)) begin
                    e_rdata    <= ERRD;
                    e_valid    <= 1'b1;
                    e_err      <= 1'b1;
                    m_inflight <= 1'b0;
                end
            end else if (host_write_req && host_read_req) begin
                e_err <= 1'b1;
            end else if (host_write_req || host_read_req) begin
                if (in_region(host_address)) begin
                    e_addr  <= SHIFT'((host_address - BASE) % (32'd1 << SHIFT));
                    e_wdata <= host_write_data;
                    e_be    <= host_byte_enable;
                    if (host_write_req) begin
                        e_wreq <= NUM'(1) << ((host_address - BASE) >> SHIFT);
                    end else begin
                        e_rreq     <= NUM'(1) << ((host_address - BASE) >> SHIFT);
                        m_sel      <= int'((host_address - BASE) >> SHIFT);
                        m_inflight <= 1'b1;
                        m_issue    <= cyc;
                    end
                end else begin
                    e_err <= 1'b1;
                    if (host_read_req) begin
                        e_rdata <= ERRD;
                        e_valid <= 1'b1;
                    end
                end
            end
        end
    end

    // Every cycle, on the falling edge, compare all outputs with the model.
    always @(negedge clk) begin
        chk("m_rdata", host_read_data, e_rdata);
        chk("m_valid", 32'(host_read_data_valid), 32'(e_valid));
        chk("m_busy",  32'(host_busy), 32'(m_inflight));
        chk("m_error", 32'(host_error), 32'(e_err));
        chk("m_daddr", 32'(dev_address), 32'(e_addr));
        chk("m_wdata", dev_write_data, e_wdata);
        chk("m_be",    32'(dev_byte_enable), 32'(e_be));
        chk("m_wreq",  32'(dev_write_req), 32'(e_wreq));
        chk("m_rreq",  32'(dev_read_req), 32'(e_rreq));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        host_address     = a;
        host_write_req   = wr;
        host_read_req    = rd;
        host_write_data  = d;
        host_byte_enable = be;
        tick();
        host_write_req   = 1'b0;
        host_read_req    = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_rdata", host_read_data, 32'h0);
        chk("rst_busy", 32'(host_busy), 32'h0);
        reset_n = 1'b1;
        tick();

        // Write to device 2, offset 4.
        req(1'b1, 1'b0, 32'h8000_0204, 32'h0000_00A5, 4'b0001);
        chk("wr_wreq", 32'(dev_write_req), 32'h4);
        chk("wr_addr", 32'(dev_address), 32'h04);
        chk("wr_data", dev_write_data, 32'hA5);
        chk("wr_be", 32'(dev_byte_enable), 32'h1);
        chk("wr_noerr", 32'(host_error), 32'h0);
        tick();
        chk("wr_onecyc", 32'(dev_write_req), 32'h0);

        // Read device 1, answering one cycle after the strobe.
        req(1'b0, 1'b1, 32'h8000_0100, '0, '0);
        chk("rd_rreq", 32'(dev_read_req), 32'h2);
        chk("rd_busy1", 32'(host_busy), 32'h1);
        tick();
        chk("rd_busy2", 32'(host_busy), 32'h1);
        dev_read_data[32*1 +: 32] = 32'h0000_000C;
        dev_read_data_valid = 4'b0010;
        tick();
        dev_read_data_valid = '0;
        chk("rd_valid", 32'(host_read_data_valid), 32'h1);
        chk("rd_data", host_read_data, 32'hC);
        chk("rd_noerr", 32'(host_error), 32'h0);
        chk("rd_idle", 32'(host_busy), 32'h0);
        tick();

        // Read device 3 which never answers.
        req(1'b0, 1'b1, 32'h8000_0300, '0, '0);
        repeat (15) tick();
        chk("to_busy16", 32'(host_busy), 32'h1);
        chk("to_novalid16", 32'(host_read_data_valid), 32'h0);
        tick();
        chk("to_valid", 32'(host_read_data_valid), 32'h1);
        chk("to_err", 32'(host_error), 32'h1);
        chk("to_data", host_read_data, ERRD);
        chk("to_idle", 32'(host_busy), 32'h0);
        tick();

        // Unmapped read and write.
        req(1'b0, 1'b1, 32'h1000_0000, '0, '0);
        chk("miss_valid", 32'(host_read_data_valid), 32'h1);
        chk("miss_err", 32'(host_error), 32'h1);
        chk("miss_data", host_read_data, ERRD);
        chk("miss_rreq", 32'(dev_read_req), 32'h0);
        req(1'b1, 1'b0, 32'h1000_0000, 32'h1111_2222, 4'hF);
        chk("wmiss_err", 32'(host_error), 32'h1);
        chk("wmiss_wreq", 32'(dev_write_req), 32'h0);
        tick();

        // Write while a read is in flight, then both requests together.
        req(1'b0, 1'b1, 32'h8000_0200, '0, '0);
        req(1'b1, 1'b0, 32'h8000_0000, 32'h3333_4444, 4'hF);
        chk("busy_err", 32'(host_error), 32'h1);
        chk("busy_wreq", 32'(dev_write_req), 32'h0);
        dev_read_data[32*2 +: 32] = 32'h0000_1234;
        dev_read_data_valid = 4'b0100;
        tick();
        dev_read_data_valid = '0;
        chk("busy_rdvalid", 32'(host_read_data_valid), 32'h1);
        chk("busy_rddata", host_read_data, 32'h1234);
        chk("busy_rdnoerr", 32'(host_error), 32'h0);
        req(1'b1, 1'b1, 32'h8000_0100, 32'h5555_6666, 4'hF);
        chk("both_err", 32'(host_error), 32'h1);
        chk("both_strb", 32'({dev_write_req, dev_read_req}), 32'h0);
        tick();

        // Valid arrives on the timeout cycle; stray valid from another device earlier.
        req(1'b0, 1'b1, 32'h8000_0000, '0, '0);
        repeat (3) tick();
        dev_read_data[32*3 +: 32] = 32'h9999_9999;
        dev_read_data_valid = 4'b1000;
        tick();
        dev_read_data_valid = '0;
        repeat (11) tick();
        chk("edge_busy16", 32'(host_busy), 32'h1);
        dev_read_data[32*0 +: 32] = 32'h0000_0055;
        dev_read_data_valid = 4'b0001;
        tick();
        dev_read_data_valid = '0;
        chk("edge_valid", 32'(host_read_data_valid), 32'h1);
        chk("edge_noerr", 32'(host_error), 32'h0);
        chk("edge_data", host_read_data, 32'h55);
        tick();

        // Reset during READ_WAIT; a late device answer is ignored.
        req(1'b0, 1'b1, 32'h8000_0100, '0, '0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(host_busy), 32'h0);
        chk("mrst_rreq", 32'(dev_read_req), 32'h0);
        chk("mrst_rdata", host_read_data, 32'h0);
        chk("mrst_daddr", 32'(dev_address), 32'h0);
        tick();
        reset_n = 1'b1;
        dev_read_data[32*1 +: 32] = 32'h7777_7777;
        dev_read_data_valid = 4'b0010;
        tick();
        dev_read_data_valid = '0;
        chk("mrst_novalid", 32'(host_read_data_valid), 32'h0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
